// File: rtl/arbiter.sv
// Round-robin arbiter.
// Picks one requester starting from the current priority index. The priority
// moves to the entry after the winner only when update_lru is asserted.
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   request[N-1:0]    request vector
//   update_lru        winner was consumed this cycle; rotate priority
//   grant_oh[N-1:0]   one-hot grant, combinational from request/priority
module arbiter #(
  parameter int NUM_ENTRIES = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_ENTRIES-1:0] request,
  input  logic                   update_lru,
  output logic [NUM_ENTRIES-1:0] grant_oh
);
  localparam int IDX_W = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;

  logic [IDX_W-1:0]       prio_q, prio_d;
  logic [NUM_ENTRIES-1:0] req_hi;
  logic [NUM_ENTRIES-1:0] pick_vec;
  logic [IDX_W-1:0]       win;
  logic                   found;

  // Requests at or above the priority index win over the wrapped-around ones.
  always_comb begin
    req_hi   = '0;
    win      = '0;
    found    = 1'b0;
    grant_oh = '0;
    for (int i = 0; i < NUM_ENTRIES; i++)
      req_hi[i] = request[i] && (IDX_W'(i) >= prio_q);
    pick_vec = (|req_hi) ? req_hi : request;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (!found && pick_vec[i]) begin
        found       = 1'b1;
        win         = IDX_W'(i);
        grant_oh[i] = 1'b1;
      end
    end
    prio_d = prio_q;
    if (update_lru && found)
      prio_d = (win == IDX_W'(NUM_ENTRIES - 1)) ? '0 : win + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) prio_q <= '0;
    else       prio_q <= prio_d;
  end
endmodule

// File: rtl/port_request_mux_port_fifo2.sv
// port_fifo2: 2-entry per-port request buffer.
// Ports:
//   clk, reset     clock, asynchronous active-high reset
//   enq_valid      source offers a beat (captured only when in_ready)
//   enq_data       payload of the offered beat
//   deq            head entry consumed this cycle
//   in_ready       buffer has space (decoded from registered count only)
//   nonempty       buffer holds at least one entry
//   head_data      oldest buffered payload
module port_fifo2 #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enq_valid,
  input  logic [DATA_WIDTH-1:0] enq_data,
  input  logic                  deq,
  output logic                  in_ready,
  output logic                  nonempty,
  output logic [DATA_WIDTH-1:0] head_data
);
  logic [1:0]                 count_q, count_d;
  logic                       wr_ptr_q, wr_ptr_d;
  logic                       rd_ptr_q, rd_ptr_d;
  logic [1:0][DATA_WIDTH-1:0] slot_q, slot_d;
  logic                       enq, deq_ok;

  always_comb begin
    in_ready  = (count_q != 2'd2);
    nonempty  = (count_q != 2'd0);
    head_data = slot_q[rd_ptr_q];
    enq       = enq_valid && in_ready;
    deq_ok    = deq && nonempty;
    wr_ptr_d  = enq    ? ~wr_ptr_q : wr_ptr_q;
    rd_ptr_d  = deq_ok ? ~rd_ptr_q : rd_ptr_q;
    slot_d    = slot_q;
    if (enq) slot_d[wr_ptr_q] = enq_data;
    // Simultaneous enq/deq (only reachable at count 1) leaves count alone.
    case ({enq, deq_ok})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q  <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Payload slots are qualified by count, so they carry no reset.
  always_ff @(posedge clk) slot_q <= slot_d;
endmodule

// File: rtl/port_request_mux.sv
// port_request_mux: funnels NUM_PORTS valid/ready request streams onto one
// shared valid/ready output through per-port 2-entry buffers and a
// round-robin arbiter. Once presented, a request stays stable until accepted.
// Ports:
//   clk, reset     clock, asynchronous active-high reset
//   in_valid/in_data/in_ready   per-port request streams (port i at
//                               in_data[i*DATA_WIDTH +: DATA_WIDTH])
//   out_valid/out_data/out_ready  shared output stream
//   out_port_oh    one-hot source port of the presented request
module port_request_mux #(
  parameter int NUM_PORTS  = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_PORTS-1:0]            in_valid,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] in_data,
  output logic [NUM_PORTS-1:0]            in_ready,
  output logic                            out_valid,
  output logic [DATA_WIDTH-1:0]           out_data,
  output logic [NUM_PORTS-1:0]            out_port_oh,
  input  logic                            out_ready
);
  logic [NUM_PORTS-1:0]                 nonempty;
  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] head_data;
  logic [NUM_PORTS-1:0]                 arb_req;
  logic [NUM_PORTS-1:0]                 deq;
  logic                                 accept;
  logic                                 lock_valid_q, lock_valid_d;
  logic [NUM_PORTS-1:0]                 lock_oh_q, lock_oh_d;

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
    port_fifo2 #(.DATA_WIDTH(DATA_WIDTH)) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .enq_valid (in_valid[i]),
      .enq_data  (in_data[i*DATA_WIDTH +: DATA_WIDTH]),
      .deq       (deq[i]),
      .in_ready  (in_ready[i]),
      .nonempty  (nonempty[i]),
      .head_data (head_data[i])
    );
  end

  arbiter #(.NUM_ENTRIES(NUM_PORTS)) u_arb (
    .clk        (clk),
    .reset      (reset),
    .request    (arb_req),
    .update_lru (accept),
    .grant_oh   (out_port_oh)
  );

  always_comb begin
    out_valid = |nonempty;
    accept    = out_valid && out_ready;
    deq       = out_port_oh & {NUM_PORTS{out_ready}};
    // A stalled request pins the arbiter to its port so late arrivals with
    // higher priority cannot swap the output before it is taken.
    arb_req   = lock_valid_q ? lock_oh_q : nonempty;
    out_data  = '0;
    for (int i = 0; i < NUM_PORTS; i++)
      out_data = out_data | (head_data[i] & {DATA_WIDTH{out_port_oh[i]}});
    lock_valid_d = out_valid && !out_ready;
    lock_oh_d    = lock_valid_d ? out_port_oh : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lock_valid_q <= 1'b0;
      lock_oh_q    <= '0;
    end else begin
      lock_valid_q <= lock_valid_d;
      lock_oh_q    <= lock_oh_d;
    end
  end
endmodule
